// File: rtl/hdmi_timing_gen.sv
// Parametrised video timing generator (hsync/vsync/de/sof) with a colour-bar pixel source.
// Define HDMI_STREAM_IN_EN to add a valid/ready pixel stream input, selectable per frame.
module hdmi_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int DATA_W   = 24,
  parameter int BARS     = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  output logic              busy_o,
  output logic              vsync_o,
  output logic              hsync_o,
  output logic              de_o,
  output logic [DATA_W-1:0] data_o,
  output logic              sof_o,
  output logic [15:0]       frame_cnt_o
`ifdef HDMI_STREAM_IN_EN
  ,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic              src_sel_i,
  output logic              underflow_o
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = DATA_W / 3;
  localparam int BAR_W   = H_ACTIVE / BARS;
  localparam int BPW     = $clog2(BAR_W + 1);
  localparam int BIW     = $clog2(BARS + 1);

  // Region bounds carry one extra bit so an end bound equal to the total still fits.
  localparam logic [HW:0]    H_ACT_END = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]    HS_BEG    = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0]    HS_END    = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0]  H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW:0]    V_ACT_END = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]    VS_BEG    = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0]    VS_END    = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [BPW-1:0] BAR_LAST  = BPW'(BAR_W - 1);
  localparam logic           HS_ON     = 1'(HS_POL);
  localparam logic           VS_ON     = 1'(VS_POL);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [BPW-1:0]    bar_px;
  logic [BIW-1:0]    bar_idx;
  logic [2:0]        bar_sel;
  logic              h_last, v_last, frame_wrap;
  logic              run, pix_act, hs_act, vs_act, sof_nxt;
  logic              stream_sel;
  logic [DATA_W-1:0] bar_rgb, pix_nxt;

  assign h_last     = (h_cnt == H_LAST);
  assign v_last     = (v_cnt == V_LAST);
  assign frame_wrap = h_last && v_last;

  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers sample the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // A run stops only at the frame wrap; a dropped en_i mid-frame finishes the frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_i) state_nxt = RUN;
      RUN:     if (frame_wrap && !en_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: each variable gets a default at the top of the block, so no path
  // through it can leave a value unassigned and infer a latch.
  always_comb begin
    run     = (state == RUN);
    pix_act = run && ({1'b0, h_cnt} < H_ACT_END) && ({1'b0, v_cnt} < V_ACT_END);
    hs_act  = run && ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
    vs_act  = run && ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);
    sof_nxt = run && (h_cnt == '0) && (v_cnt == '0);
    bar_sel = 3'(bar_idx);
    // Bar order white..black maps to inverted index bits: R=~b1, G=~b2, B=~b0.
    bar_rgb = {{CW{~bar_sel[1]}}, {CW{~bar_sel[2]}}, {CW{~bar_sel[0]}}};
    pix_nxt = '0;
    if (pix_act) begin
`ifdef HDMI_STREAM_IN_EN
      if (stream_sel) pix_nxt = s_valid_i ? s_data_i : '0;
      else            pix_nxt = bar_rgb;
`else
      pix_nxt = bar_rgb;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end
  end

  // Bar position tracked by a pixel-within-bar counter instead of dividing h_cnt.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (!run || h_last) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if ({1'b0, h_cnt} < H_ACT_END) begin
      if (bar_px == BAR_LAST) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 1'b1;
      end else begin
        bar_px <= bar_px + 1'b1;
      end
    end
  end

`ifdef HDMI_STREAM_IN_EN
  logic frame_start;

  // Source choice is frozen per frame so a frame never mixes bars and stream data.
  assign frame_start = en_i && ((state == IDLE) || frame_wrap);
  assign s_ready_o   = pix_act && stream_sel;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stream_sel  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (frame_start) stream_sel <= src_sel_i;
      underflow_o <= (underflow_o && !sof_nxt) || (s_ready_o && !s_valid_i);
    end
  end
`else
  assign stream_sel = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_o      <= 1'b0;
      hsync_o     <= ~HS_ON;
      vsync_o     <= ~VS_ON;
      de_o        <= 1'b0;
      data_o      <= '0;
      sof_o       <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      busy_o  <= run;
      hsync_o <= hs_act ? HS_ON : ~HS_ON;
      vsync_o <= vs_act ? VS_ON : ~VS_ON;
      de_o    <= pix_act;
      data_o  <= pix_nxt;
      sof_o   <= sof_nxt;
      if (sof_nxt) frame_cnt_o <= frame_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen: a default 1080p instance for line/bar timing and a
// tiny active-low instance (14x7 totals) for frame-level start/stop behaviour.
module tb_hdmi_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_en, a_busy, a_vs, a_hs, a_de, a_sof;
  logic [23:0] a_data;
  logic [15:0] a_fc;
  logic        b_en, b_busy, b_vs, b_hs, b_de, b_sof;
  logic [23:0] b_data;
  logic [15:0] b_fc;
`ifdef HDMI_STREAM_IN_EN
  logic [23:0] a_sdata, b_sdata;
  logic        a_svalid, b_svalid, a_ready, b_ready, a_src, b_src, a_uf, b_uf;
`endif

  hdmi_timing_gen dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(a_en), .busy_o(a_busy), .vsync_o(a_vs),
    .hsync_o(a_hs), .de_o(a_de), .data_o(a_data), .sof_o(a_sof), .frame_cnt_o(a_fc)
`ifdef HDMI_STREAM_IN_EN
    , .s_data_i(a_sdata), .s_valid_i(a_svalid), .s_ready_o(a_ready),
    .src_sel_i(a_src), .underflow_o(a_uf)
`endif
  );

  hdmi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0)
  ) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(b_en), .busy_o(b_busy), .vsync_o(b_vs),
    .hsync_o(b_hs), .de_o(b_de), .data_o(b_data), .sof_o(b_sof), .frame_cnt_o(b_fc)
`ifdef HDMI_STREAM_IN_EN
    , .s_data_i(b_sdata), .s_valid_i(b_svalid), .s_ready_o(b_ready),
    .src_sel_i(b_src), .underflow_o(b_uf)
`endif
  );

  typedef struct {
    bit          sel;   // 0: dut_a log, 1: dut_b log
    int          idx;   // cycles after sof_o
    logic [27:0] exp;   // {de, hsync, vsync, sof, data}
  } vec_t;

  vec_t        vecs[$];
  logic [27:0] a_log [0:2200];
  logic [27:0] b_log [0:199];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit sel, input int idx, input bit de, input bit hs, input bit vs,
                     input bit sof, input logic [23:0] d);
    vec_t v;
    v.sel = sel;
    v.idx = idx;
    v.exp = {de, hs, vs, sof, d};
    vecs.push_back(v);
  endtask

  task automatic wait_sof(input bit sel, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      ok = sel ? b_sof : a_sof;
    end
  endtask

  task automatic wait_b_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      ok = !b_busy;
    end
  endtask

`ifdef HDMI_STREAM_IN_EN
  // Counting source: word N offered for the N-th ready cycle, but withheld for N=5.
  task automatic drive_stream(input int cycles);
    int cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (b_ready) begin
        b_sdata  = 24'(cnt);
        b_svalid = (cnt != 5);
        cnt++;
      end else begin
        b_sdata  = 24'hABCDEF;
        b_svalid = 1'b0;
      end
    end
  endtask
`endif

  initial begin
    bit ok;
    int k, stop_k, found, dropped, n_sof, de_n, hs_n, de_fall, hs_first;
    logic [15:0] fc98;
`ifdef HDMI_STREAM_IN_EN
    logic [25:0] s_log [0:99];
`endif

    // 1080p line 0 (and first pixel of line 1): bars, blanking, hsync (active-high)
    add(0, 0,    1, 0, 0, 1, 24'hFFFFFF);
    add(0, 1,    1, 0, 0, 0, 24'hFFFFFF);
    add(0, 239,  1, 0, 0, 0, 24'hFFFFFF);
    add(0, 240,  1, 0, 0, 0, 24'hFFFF00);
    add(0, 479,  1, 0, 0, 0, 24'hFFFF00);
    add(0, 480,  1, 0, 0, 0, 24'h00FFFF);
    add(0, 720,  1, 0, 0, 0, 24'h00FF00);
    add(0, 960,  1, 0, 0, 0, 24'hFF00FF);
    add(0, 1200, 1, 0, 0, 0, 24'hFF0000);
    add(0, 1440, 1, 0, 0, 0, 24'h0000FF);
    add(0, 1680, 1, 0, 0, 0, 24'h000000);
    add(0, 1919, 1, 0, 0, 0, 24'h000000);
    add(0, 1920, 0, 0, 0, 0, 24'h000000);
    add(0, 2007, 0, 0, 0, 0, 24'h000000);
    add(0, 2008, 0, 1, 0, 0, 24'h000000);
    add(0, 2051, 0, 1, 0, 0, 24'h000000);
    add(0, 2052, 0, 0, 0, 0, 24'h000000);
    add(0, 2199, 0, 0, 0, 0, 24'h000000);
    add(0, 2200, 1, 0, 0, 0, 24'hFFFFFF);
    // Tiny mode, idx = v*14 + h, one-pixel bars, active-low syncs
    add(1, 0,   1, 1, 1, 1, 24'hFFFFFF);
    add(1, 1,   1, 1, 1, 0, 24'hFFFF00);
    add(1, 2,   1, 1, 1, 0, 24'h00FFFF);
    add(1, 3,   1, 1, 1, 0, 24'h00FF00);
    add(1, 4,   1, 1, 1, 0, 24'hFF00FF);
    add(1, 5,   1, 1, 1, 0, 24'hFF0000);
    add(1, 6,   1, 1, 1, 0, 24'h0000FF);
    add(1, 7,   1, 1, 1, 0, 24'h000000);
    add(1, 8,   0, 1, 1, 0, 24'h000000);
    add(1, 9,   0, 1, 1, 0, 24'h000000);
    add(1, 10,  0, 0, 1, 0, 24'h000000);
    add(1, 11,  0, 0, 1, 0, 24'h000000);
    add(1, 12,  0, 1, 1, 0, 24'h000000);
    add(1, 13,  0, 1, 1, 0, 24'h000000);
    add(1, 14,  1, 1, 1, 0, 24'hFFFFFF);
    add(1, 44,  1, 1, 1, 0, 24'h00FFFF);
    add(1, 55,  0, 1, 1, 0, 24'h000000);
    add(1, 56,  0, 1, 1, 0, 24'h000000);
    add(1, 66,  0, 0, 1, 0, 24'h000000);
    add(1, 69,  0, 1, 1, 0, 24'h000000);
    add(1, 70,  0, 1, 0, 0, 24'h000000);
    add(1, 80,  0, 0, 0, 0, 24'h000000);
    add(1, 83,  0, 1, 0, 0, 24'h000000);
    add(1, 84,  0, 1, 1, 0, 24'h000000);
    add(1, 97,  0, 1, 1, 0, 24'h000000);
    add(1, 98,  1, 1, 1, 1, 24'hFFFFFF);
    add(1, 102, 1, 1, 1, 0, 24'hFF00FF);

    rst_n = 1'b0;
    a_en  = 1'b1;
    b_en  = 1'b0;
`ifdef HDMI_STREAM_IN_EN
    a_sdata = '0; a_svalid = 1'b0; a_src = 1'b0;
    b_sdata = '0; b_svalid = 1'b0; b_src = 1'b0;
`endif

    // Reset held with en_i high: everything idle
    repeat (3) @(negedge clk);
    check("rst_a_pins", {a_de, a_hs, a_vs, a_sof, a_data}, 28'h0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_fc", a_fc, 0);
    check("rst_b_pins", {b_de, b_hs, b_vs, b_busy, b_data}, {4'b0110, 24'h0});

    // Enters RUN on the first edge, first pixel registered on the next
    rst_n = 1'b1;
    @(negedge clk);
    check("a_start_early", {a_sof, a_busy}, 2'b00);
    @(negedge clk);
    check("a_start_sof", {a_sof, a_busy}, 2'b11);
    check("a_fc_first", a_fc, 1);
    for (int i = 0; i <= 2200; i++) begin
      a_log[i] = {a_de, a_hs, a_vs, a_sof, a_data};
      @(negedge clk);
    end
    a_en = 1'b0;

    de_n = 0; hs_n = 0; de_fall = -1; hs_first = -1;
    for (int i = 0; i < 2200; i++) begin
      de_n += int'(a_log[i][27]);
      hs_n += int'(a_log[i][26]);
      if (de_fall < 0 && !a_log[i][27]) de_fall = i;
      if (hs_first < 0 && a_log[i][26]) hs_first = i;
    end
    check("a_de_per_line", de_n, 1920);
    check("a_hsync_width", hs_n, 44);
    check("a_hsync_after_de", hs_first - de_fall, 88);

    // Tiny mode: two full frames of bars
    b_en = 1'b1;
    wait_sof(1, 10, ok);
    check("b_first_sof", ok, 1);
    fc98 = '0;
    for (int i = 0; i < 200; i++) begin
      b_log[i] = {b_de, b_hs, b_vs, b_sof, b_data};
      if (i == 98) fc98 = b_fc;
      @(negedge clk);
    end
    check("b_fc_frame2", fc98, 2);

    foreach (vecs[i])
      check($sformatf("%s_px%0d", vecs[i].sel ? "b" : "a", vecs[i].idx),
            vecs[i].sel ? b_log[vecs[i].idx] : a_log[vecs[i].idx], vecs[i].exp);

    // en_i dropped mid-frame: the frame completes, then idle with no new sof
    wait_sof(1, 120, ok);
    check("b_stop_sof", ok, 1);
    repeat (31) @(negedge clk);
    b_en = 1'b0;
    k = 31; stop_k = -1;
    while (k < 200 && stop_k < 0) begin
      @(negedge clk);
      k++;
      if (!b_busy) stop_k = k;
    end
    check("b_stop_at_wrap", stop_k, 98);
    check("b_stop_pins", {b_de, b_hs, b_vs, b_data}, {3'b011, 24'h0});
    n_sof = 0;
    repeat (150) begin
      @(negedge clk);
      n_sof += int'(b_sof);
    end
    check("b_idle_no_sof", n_sof, 0);
    check("b_idle_fc", b_fc, 4);

    // Re-assert from idle
    b_en = 1'b1;
    @(negedge clk);
    check("b_restart_early", b_sof, 0);
    @(negedge clk);
    check("b_restart_sof", b_sof, 1);

    // en_i low then high again before the wrap: no gap frame
    repeat (20) @(negedge clk);
    b_en = 1'b0;
    repeat (30) @(negedge clk);
    b_en = 1'b1;
    k = 50; found = -1; dropped = 0;
    while (k < 200 && found < 0) begin
      @(negedge clk);
      k++;
      if (!b_busy) dropped = 1;
      if (b_sof) found = k;
    end
    check("b_seamless_sof", found, 98);
    check("b_seamless_busy", dropped, 0);
    check("b_seamless_fc", b_fc, 6);

    // Frame counter wrap from a forced 0xFFFF
    b_en = 1'b0;
    wait_b_idle(200, ok);
    check("b_wrap_idle", ok, 1);
    force dut_b.frame_cnt_o = 16'hFFFF;
    @(negedge clk);
    release dut_b.frame_cnt_o;
    b_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("b_wrap_sof", b_sof, 1);
    check("b_fc_wrap", b_fc, 0);

`ifdef HDMI_STREAM_IN_EN
    // Stream source with one missing word at pixel 5
    b_en = 1'b0;
    wait_b_idle(200, ok);
    check("s_idle", ok, 1);
    b_src = 1'b1;
    fork
      drive_stream(130);
      begin
        b_en = 1'b1;
        wait_sof(1, 10, ok);
        check("s_sof", ok, 1);
        for (int i = 0; i < 100; i++) begin
          s_log[i] = {b_de, b_uf, b_data};
          @(negedge clk);
        end
      end
    join
    for (int n = 0; n < 8; n++)
      check($sformatf("s_px%0d", n), s_log[n], {1'b1, n >= 5, (n == 5) ? 24'h0 : 24'(n)});
    check("s_blank", s_log[8], {2'b01, 24'h0});
    check("s_line1", s_log[14], {2'b11, 24'd8});
    check("s_uf_clear", s_log[98], {2'b10, 24'd32});
`endif

    // Asynchronous reset mid-frame
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_b_pins", {b_de, b_hs, b_vs, b_sof, b_data}, {4'b0110, 24'h0});
    check("rst_mid_b_busy_fc", {b_busy, b_fc}, 17'h0);
    check("rst_mid_a_pins", {a_de, a_hs, a_vs, a_sof, a_busy, a_fc}, 21'h0);
`ifdef HDMI_STREAM_IN_EN
    check("rst_mid_stream", {a_uf, a_ready, b_uf, b_ready}, 4'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
